// File: rtl/life_datapath_if.sv
// Controller-to-datapath bundle for the 8x8 Life board: mode code, entry buttons,
// play freeze and the flat board export.
interface life_datapath_if #(
  parameter int ROWS = 8,
  parameter int COLS = 8
);
  // No valid/ready pair: state, btn0, btn1 and stop are per-cycle levels sampled
  // on every rising clka; grid is the board register, valid every cycle.
  logic [1:0]           state;
  logic                 btn0;
  logic                 btn1;
  logic                 stop;
  logic [ROWS*COLS-1:0] grid;

  modport master (output state, btn0, btn1, stop, input grid);
  modport slave  (input state, btn0, btn1, stop, output grid);
endinterface

// File: rtl/life_datapath.sv
// Board register, entry cursor and combinational next-generation logic for
// Conway's Game of Life with a dead (non-wrapping) border.
module life_datapath #(
  parameter int ROWS = 8,
  parameter int COLS = 8
) (
  input  logic          clka,
  input  logic          rst,
  life_datapath_if.slave bus
);
  localparam int N  = ROWS * COLS;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] ST_CLEAR = 2'b00;
  localparam logic [1:0] ST_ENTRY = 2'b01;
  localparam logic [1:0] ST_PLAY  = 2'b10;
  localparam logic [1:0] ST_HOLD  = 2'b11;

  logic [N-1:0]  board;
  logic [N-1:0]  nxt;
  logic [CW-1:0] cursor;
  logic [CW-1:0] cursor_inc;

  // Board framed by a ring of constant zeros so every cell sees 8 neighbours.
  logic [ROWS+1:0][COLS+1:0] pad;

  genvar pr, pc;
  generate
    for (pr = 0; pr < ROWS + 2; pr++) begin : g_pad_r
      for (pc = 0; pc < COLS + 2; pc++) begin : g_pad_c
        if (pr == 0 || pr == ROWS + 1 || pc == 0 || pc == COLS + 1) begin : g_edge
          assign pad[pr][pc] = 1'b0;
        end else begin : g_cell
          assign pad[pr][pc] = board[(pr-1)*COLS + (pc-1)];
        end
      end
    end

    for (pr = 0; pr < ROWS; pr++) begin : g_row
      for (pc = 0; pc < COLS; pc++) begin : g_col
        logic [3:0] n;
        assign n = {3'b000, pad[pr][pc]}   + {3'b000, pad[pr][pc+1]}   + {3'b000, pad[pr][pc+2]}
                 + {3'b000, pad[pr+1][pc]}                              + {3'b000, pad[pr+1][pc+2]}
                 + {3'b000, pad[pr+2][pc]} + {3'b000, pad[pr+2][pc+1]} + {3'b000, pad[pr+2][pc+2]};
        assign nxt[pr*COLS + pc] = (n == 4'd3) | (board[pr*COLS + pc] & (n == 4'd2));
      end
    end
  endgenerate

  assign cursor_inc = (cursor == LAST) ? '0 : cursor + 1'b1;

  always_ff @(posedge clka) begin
    if (rst) begin
      board  <= '0;
      cursor <= '0;
    end else begin
      case (bus.state)
        ST_CLEAR: begin
          board  <= '0;
          cursor <= '0;
        end
        ST_ENTRY: begin
          // btn0 wins when both are pressed: the written value is simply btn0.
          if (bus.btn0 || bus.btn1) begin
            board[cursor] <= bus.btn0;
            cursor        <= cursor_inc;
          end
        end
        ST_PLAY: begin
          if (!bus.stop) board <= nxt;
        end
        ST_HOLD: ;
        default: ;
      endcase
    end
  end

  assign bus.grid = board;
endmodule

// File: tb/tb_life_datapath.sv
// Directed bench for life_datapath: a 2-D Life model is stepped alongside the DUT
// and compared every cycle, with hand-computed board values checked at key points.
module tb_life_datapath;
  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int N    = ROWS * COLS;

  logic clka = 1'b0;
  logic rst  = 1'b1;

  life_datapath_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

  life_datapath #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clka (clka),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 clka = ~clka;

  int total = 0;
  int bad   = 0;
  bit chk   = 1'b0;

  logic [N-1:0] m_grid = '0;
  int           m_cur  = 0;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Neighbour count over a 2-D view with out-of-board positions treated as dead.
  function automatic logic [N-1:0] life_next(input logic [N-1:0] g);
    logic [N-1:0] r;
    int n;
    r = '0;
    for (int row = 0; row < ROWS; row++) begin
      for (int col = 0; col < COLS; col++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if ((dr != 0 || dc != 0) && row+dr >= 0 && row+dr < ROWS && col+dc >= 0 && col+dc < COLS)
              n += int'(g[(row+dr)*COLS + (col+dc)]);
          end
        end
        r[row*COLS + col] = (n == 3) || (g[row*COLS + col] && n == 2);
      end
    end
    return r;
  endfunction

  // Drive one clock of inputs, advance the model at the edge, return at the next negedge.
  task automatic cyc(input logic r, input logic [1:0] st, input logic b0, input logic b1, input logic sp);
    rst      = r;
    bus.state = st;
    bus.btn0 = b0;
    bus.btn1 = b1;
    bus.stop = sp;
    @(posedge clka);
    if (r) begin
      m_grid = '0;
      m_cur  = 0;
    end else begin
      case (st)
        2'b00: begin m_grid = '0; m_cur = 0; end
        2'b01: if (b0 || b1) begin
          m_grid[m_cur] = b0;
          m_cur = (m_cur + 1) % N;
        end
        2'b10: if (!sp) m_grid = life_next(m_grid);
        default: ;
      endcase
    end
    @(negedge clka);
  endtask

  task automatic press(input logic b0, input logic b1, input int cnt);
    for (int i = 0; i < cnt; i++) cyc(1'b0, 2'b01, b0, b1, 1'b0);
  endtask

  task automatic play(input logic sp, input int cnt);
    for (int i = 0; i < cnt; i++) cyc(1'b0, 2'b10, 1'b0, 1'b0, sp);
  endtask

  // Literal check pins both the DUT and the model to a hand-computed board.
  task automatic lit(input string name, input logic [N-1:0] exp);
    check(name, bus.grid, exp);
    check({name, "_model"}, m_grid, exp);
  endtask

  always @(negedge clka) begin
    if (chk) check("cycle", bus.grid, m_grid);
  end

  initial begin
    bus.state = 2'b10;
    bus.btn0  = 1'b1;
    bus.btn1  = 1'b0;
    bus.stop  = 1'b0;
    @(negedge clka);

    // Reset with arbitrary mode and buttons active.
    cyc(1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 2'b01, 1'b1, 1'b1, 1'b0);
    chk = 1'b1;
    lit("reset", 64'h0);
    press(1'b1, 1'b0, 1);
    lit("first_entry", 64'h1);

    // Serial entry sequence.
    cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    lit("clear", 64'h0);
    press(1'b1, 1'b0, 1);
    press(1'b0, 1'b1, 5);
    press(1'b1, 1'b0, 1);
    press(1'b0, 1'b1, 1);
    press(1'b1, 1'b0, 2);
    press(1'b0, 1'b1, 1);
    lit("entry_seq", 64'h0000_0000_0000_0341);

    // Evolution into a still-life block.
    play(1'b0, 1);
    lit("gen1_block", 64'h303);
    play(1'b0, 2);
    lit("block_still", 64'h303);

    // Blinker with stop.
    cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    press(1'b0, 1'b1, 19);
    press(1'b1, 1'b0, 3);
    lit("blinker_load", 64'h0000_0000_0038_0000);
    play(1'b0, 1);
    lit("blinker_vert", 64'h0000_0000_1010_1000);
    play(1'b1, 3);
    lit("blinker_stop", 64'h0000_0000_1010_1000);
    play(1'b0, 1);
    lit("blinker_back", 64'h0000_0000_0038_0000);

    // Hold mode ignores buttons and stop.
    cyc(1'b0, 2'b11, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 2'b11, 1'b0, 1'b1, 1'b1);
    lit("hold", 64'h0000_0000_0038_0000);

    // Top-edge blinker: no wrap into row 7.
    cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    press(1'b1, 1'b0, 3);
    lit("edge_load", 64'h7);
    play(1'b0, 1);
    lit("edge_gen1", 64'h202);

    // Cursor wrap, then clear resets the cursor.
    cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    press(1'b0, 1'b1, 64);
    press(1'b1, 1'b0, 1);
    lit("wrap", 64'h1);
    cyc(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    lit("wrap_clear", 64'h0);
    press(1'b1, 1'b0, 1);
    lit("after_clear", 64'h1);

    // Both buttons write 1; leaving entry keeps the cursor.
    press(1'b1, 1'b1, 1);
    cyc(1'b0, 2'b11, 1'b0, 1'b0, 1'b0);
    play(1'b1, 1);
    press(1'b1, 1'b0, 1);
    lit("cursor_kept", 64'h7);

    // Reset mid-play has priority.
    play(1'b0, 1);
    cyc(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
    lit("reset_midplay", 64'h0);
    press(1'b1, 1'b0, 1);
    lit("reset_cursor", 64'h1);

    chk = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
